// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
// Shared definitions for the stream demultiplexer slice.
//   DATA_WD_DEF    : default payload width (bits)
//   sel_e          : route-select encoding (SEL_B = 0, SEL_C = 1)
//   skid_state_e   : occupancy of a 2-entry skid buffer
// Used by stream_demux and stream_skid_buf. The registered build is selected
// with the STREAM_DEMUX_REG_EN macro (see stream_demux).
// -----------------------------------------------------------------------------
package stream_pkg;

    localparam int unsigned DATA_WD_DEF = 32;

    typedef enum logic {
        SEL_B = 1'b0,
        SEL_C = 1'b1
    } sel_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage : stream_pkg

// File: rtl/stream_skid_buf.sv
// -----------------------------------------------------------------------------
// stream_skid_buf
// Two-entry valid/ready skid buffer with registered outputs.
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset, empties the buffer
//   in_data_i    : upstream payload
//   in_valid_i   : upstream valid
//   in_ready_o   : upstream ready (registered "not full", forced 0 in reset)
//   out_data_o   : downstream payload (head entry)
//   out_valid_o  : downstream valid (registered "not empty")
//   out_ready_i  : downstream ready
// Latency from an input transfer to output valid is one cycle; with
// out_ready_i held high the buffer passes one word per cycle.
// -----------------------------------------------------------------------------
module stream_skid_buf
    import stream_pkg::*;
#(
    parameter int unsigned DATA_WD = DATA_WD_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [DATA_WD-1:0] in_data_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic [DATA_WD-1:0] out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    skid_state_e        state_q, state_d;
    logic [DATA_WD-1:0] head_q, head_d;
    logic [DATA_WD-1:0] skid_q, skid_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic               in_fire;
    logic               out_fire;

    // Reset gating keeps the interface quiet for every cycle rst_i is high,
    // including the first one before the registers have been cleared.
    assign in_ready_o  = ready_q & ~rst_i;
    assign out_valid_o = valid_q & ~rst_i;
    assign out_data_o  = rst_i ? '0 : head_q;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SKID_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;

        case (state_q)
            SKID_EMPTY: begin
                if (in_fire) begin
                    head_d  = in_data_i;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                case ({in_fire, out_fire})
                    2'b10: begin
                        skid_d  = in_data_i;
                        state_d = SKID_FULL;
                    end
                    2'b01: begin
                        state_d = SKID_EMPTY;
                    end
                    2'b11: begin
                        // Head leaves and is replaced in the same cycle:
                        // occupancy stays at one.
                        head_d = in_data_i;
                    end
                    default: begin
                    end
                endcase
            end
            SKID_FULL: begin
                // in_ready_o is low here, so only the output can move.
                if (out_fire) begin
                    head_d  = skid_q;
                    state_d = SKID_ONE;
                end
            end
            default: begin
                state_d = SKID_EMPTY;
            end
        endcase

        // Flags are precomputed from the next state so the outputs
        // come straight from flops.
        valid_d = (state_d != SKID_EMPTY);
        ready_d = (state_d != SKID_FULL);
    end

endmodule : stream_skid_buf

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
// Routes one valid/ready input stream to one of two output streams.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (no effect in pass-through build)
//   sel      : route select, SEL_B (0) -> b, SEL_C (1) -> c, sampled per word
//   a_data / a_valid / a_ready : upstream stream
//   b_data / b_valid / b_ready : downstream stream b
//   c_data / c_valid / c_ready : downstream stream c
// Build option:
//   STREAM_DEMUX_REG_EN defined   : each branch has a 2-entry registered skid
//                                   buffer, 1-cycle latency, a_ready from the
//                                   selected branch's registered not-full flag.
//   STREAM_DEMUX_REG_EN undefined : combinational pass-through, 0 latency.
// -----------------------------------------------------------------------------
module stream_demux
    import stream_pkg::*;
#(
    parameter int unsigned DATA_WD = DATA_WD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sel,
    input  logic [DATA_WD-1:0] a_data,
    input  logic               a_valid,
    output logic               a_ready,
    output logic [DATA_WD-1:0] b_data,
    output logic               b_valid,
    input  logic               b_ready,
    output logic [DATA_WD-1:0] c_data,
    output logic               c_valid,
    input  logic               c_ready
);

`ifdef STREAM_DEMUX_REG_EN

    logic b_in_valid;
    logic b_in_ready;
    logic c_in_valid;
    logic c_in_ready;

    // Only the selected branch sees a_valid; a_ready comes from that
    // branch's registered flag and therefore never depends on a_valid.
    assign b_in_valid = a_valid & (sel == SEL_B);
    assign c_in_valid = a_valid & (sel == SEL_C);
    assign a_ready    = (sel == SEL_C) ? c_in_ready : b_in_ready;

    stream_skid_buf #(
        .DATA_WD (DATA_WD)
    ) u_skid_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (a_data),
        .in_valid_i  (b_in_valid),
        .in_ready_o  (b_in_ready),
        .out_data_o  (b_data),
        .out_valid_o (b_valid),
        .out_ready_i (b_ready)
    );

    stream_skid_buf #(
        .DATA_WD (DATA_WD)
    ) u_skid_c (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (a_data),
        .in_valid_i  (c_in_valid),
        .in_ready_o  (c_in_ready),
        .out_data_o  (c_data),
        .out_valid_o (c_valid),
        .out_ready_i (c_ready)
    );

`else

    // Pass-through: no state, so clk and rst are intentionally unused.
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, rst};

    assign b_valid = a_valid & (sel == SEL_B);
    assign c_valid = a_valid & (sel == SEL_C);
    assign b_data  = a_data;
    assign c_data  = a_data;
    assign a_ready = (sel == SEL_C) ? c_ready : b_ready;

`endif

endmodule : stream_demux

// File: tb/tb_stream_demux.sv
module tb_stream_demux;
    import stream_pkg::*;

    localparam int unsigned W = 32;
`ifdef STREAM_DEMUX_REG_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         sel;
    logic [W-1:0] a_data;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] b_data;
    logic         b_valid;
    logic         b_ready;
    logic [W-1:0] c_data;
    logic         c_valid;
    logic         c_ready;

    int checks = 0;
    int errors = 0;

    // Reference model: words accepted on a and not yet delivered, per branch.
    logic [W-1:0] exp_b[$];
    logic [W-1:0] exp_c[$];
    logic [W-1:0] got_b[$];
    logic [W-1:0] got_c[$];
    int           sb_bad = 0;
    int           nb_a = 0;
    int           hold_viol = 0;
    logic         prev_b_stall = 1'b0;
    logic         prev_c_stall = 1'b0;
    logic         prev_rst = 1'b0;
    logic [W-1:0] prev_b_data = '0;
    logic [W-1:0] prev_c_data = '0;

    always #5 clk = ~clk;

    stream_demux #(.DATA_WD(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .sel     (sel),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .c_data  (c_data),
        .c_valid (c_valid),
        .c_ready (c_ready)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Observe one cycle just before its rising edge, update the model,
    // then move to the next falling edge.
    task automatic step();
        #1;
        if (REG && prev_b_stall && !prev_rst && (b_valid !== 1'b1 || b_data !== prev_b_data)) hold_viol++;
        if (REG && prev_c_stall && !prev_rst && (c_valid !== 1'b1 || c_data !== prev_c_data)) hold_viol++;
        prev_b_stall = b_valid && !b_ready;
        prev_c_stall = c_valid && !c_ready;
        prev_b_data  = b_data;
        prev_c_data  = c_data;
        prev_rst     = rst;
        if (a_valid && a_ready) begin
            nb_a++;
            if (sel) exp_c.push_back(a_data);
            else     exp_b.push_back(a_data);
        end
        if (b_valid && b_ready) begin
            got_b.push_back(b_data);
            if (exp_b.size() == 0 || exp_b[0] !== b_data) sb_bad++;
            if (exp_b.size() != 0) void'(exp_b.pop_front());
        end
        if (c_valid && c_ready) begin
            got_c.push_back(c_data);
            if (exp_c.size() == 0 || exp_c[0] !== c_data) sb_bad++;
            if (exp_c.size() != 0) void'(exp_c.pop_front());
        end
        if (REG && rst) begin
            exp_b.delete();
            exp_c.delete();
        end
        @(negedge clk);
    endtask

    task automatic clear_log();
        got_b.delete();
        got_c.delete();
        sb_bad    = 0;
        hold_viol = 0;
    endtask

    task automatic test_reset();
        logic [W-1:0] d;
        d = $urandom;
        rst = 1'b1; sel = 1'b0; a_valid = 1'b1; a_data = d; b_ready = 1'b1; c_ready = 1'b1;
        step();
        #1;
        checks++; if (a_ready !== (REG ? 1'b0 : 1'b1)) begin errors++; $display("FAIL reset_a_ready: got %b want %b", a_ready, REG ? 1'b0 : 1'b1); end
        checks++; if (b_valid !== (REG ? 1'b0 : 1'b1)) begin errors++; $display("FAIL reset_b_valid: got %b want %b", b_valid, REG ? 1'b0 : 1'b1); end
        checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL reset_c_valid: got %b want 0", c_valid); end
        checks++; if (b_data !== (REG ? '0 : d)) begin errors++; $display("FAIL reset_b_data: got %h want %h", b_data, REG ? '0 : d); end
        checks++; if (c_data !== (REG ? '0 : d)) begin errors++; $display("FAIL reset_c_data: got %h want %h", c_data, REG ? '0 : d); end
        a_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL release_a_ready: got %b want 1", a_ready); end
        checks++; if (b_valid !== 1'b0 || c_valid !== 1'b0) begin errors++; $display("FAIL release_valids: got b=%b c=%b want 0 0", b_valid, c_valid); end
        step();
    endtask

    task automatic test_single();
        clear_log();
        sel = 1'b0; a_data = 32'h5; a_valid = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_a_ready: got %b want 1", a_ready); end
        checks++; if (b_valid !== (REG ? 1'b0 : 1'b1)) begin errors++; $display("FAIL single_b_valid_pre: got %b want %b", b_valid, REG ? 1'b0 : 1'b1); end
        step();
        a_valid = 1'b0; a_data = '0;
        #1;
        checks++; if (b_valid !== REG) begin errors++; $display("FAIL single_b_valid_post: got %b want %b", b_valid, REG); end
        checks++; if (b_data !== (REG ? 32'h5 : 32'h0)) begin errors++; $display("FAIL single_b_data: got %h want %h", b_data, REG ? 32'h5 : 32'h0); end
        checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL single_c_valid: got %b want 0", c_valid); end
        step();
        checks++; if (got_b.size() != 1 || got_b[0] !== 32'h5 || got_c.size() != 0 || sb_bad != 0) begin
            errors++; $display("FAIL single_delivery: got b_n=%0d c_n=%0d bad=%0d want 1 0 0", got_b.size(), got_c.size(), sb_bad);
        end
    endtask

    task automatic test_toggle();
        int n0;
        clear_log();
        n0 = nb_a;
        b_ready = 1'b1; c_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = i[0]; a_data = 32'(i); a_valid = 1'b1;
            step();
        end
        a_valid = 1'b0;
        step();
        step();
        checks++; if (nb_a - n0 != 4) begin errors++; $display("FAIL toggle_accepted: got %0d want 4", nb_a - n0); end
        checks++; if (got_b.size() != 2 || got_b[0] !== 32'd0 || got_b[1] !== 32'd2) begin errors++; $display("FAIL toggle_b_seq: got n=%0d want 0,2", got_b.size()); end
        checks++; if (got_c.size() != 2 || got_c[0] !== 32'd1 || got_c[1] !== 32'd3) begin errors++; $display("FAIL toggle_c_seq: got n=%0d want 1,3", got_c.size()); end
        checks++; if (sb_bad != 0) begin errors++; $display("FAIL toggle_scoreboard: got %0d bad want 0", sb_bad); end
    endtask

    task automatic test_backpressure();
        int n0;
        int want_n;
        clear_log();
        n0 = nb_a;
        want_n = REG ? 2 : 0;
        b_ready = 1'b0; c_ready = 1'b1; sel = 1'b0; a_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_data = 32'hA0 + 32'(nb_a - n0);
            step();
        end
        #1;
        checks++; if (nb_a - n0 != want_n) begin errors++; $display("FAIL bp_accepted: got %0d want %0d", nb_a - n0, want_n); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_a_ready: got %b want 0", a_ready); end
        checks++; if (b_valid !== 1'b1 || b_data !== 32'hA0) begin errors++; $display("FAIL bp_b_hold: got v=%b d=%h want 1 a0", b_valid, b_data); end
        a_valid = 1'b0; b_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++; if (got_b.size() != want_n || (want_n == 2 && (got_b[0] !== 32'hA0 || got_b[1] !== 32'hA1))) begin
            errors++; $display("FAIL bp_drain: got n=%0d want %0d words a0,a1", got_b.size(), want_n);
        end
        checks++; if (hold_viol != 0 || sb_bad != 0) begin errors++; $display("FAIL bp_stable: got hold=%0d bad=%0d want 0 0", hold_viol, sb_bad); end
    endtask

    task automatic test_bypass_full();
        int  n0;
        bit  ok;
        clear_log();
        n0 = nb_a;
        b_ready = 1'b0; c_ready = 1'b1; sel = 1'b0; a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data = 32'hB0 + 32'(nb_a - n0);
            step();
        end
        checks++; if (nb_a - n0 != (REG ? 2 : 0)) begin errors++; $display("FAIL byp_fill: got %0d want %0d", nb_a - n0, REG ? 2 : 0); end
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = 32'hC0 + 32'(i);
            #1;
            checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL byp_a_ready: word %0d got %b want 1", i, a_ready); end
            step();
        end
        a_valid = 1'b0;
        step();
        step();
        #1;
        ok = (got_c.size() == 4);
        for (int i = 0; i < 4; i++) if (ok && got_c[i] !== 32'hC0 + 32'(i)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL byp_c_seq: got n=%0d want c0..c3", got_c.size()); end
        checks++; if (b_valid !== REG || b_data !== (REG ? 32'hB0 : 32'hC3)) begin
            errors++; $display("FAIL byp_b_held: got v=%b d=%h want %b %h", b_valid, b_data, REG, REG ? 32'hB0 : 32'hC3);
        end
        b_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++; if (got_b.size() != (REG ? 2 : 0) || sb_bad != 0 || hold_viol != 0) begin
            errors++; $display("FAIL byp_b_drain: got n=%0d bad=%0d hold=%0d want %0d 0 0", got_b.size(), sb_bad, hold_viol, REG ? 2 : 0);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        clear_log();
        n0 = nb_a;
        b_ready = 1'b0; c_ready = 1'b0; a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = i[0]; a_data = 32'hD0 + 32'(i);
            step();
        end
        a_valid = 1'b0;
        #1;
        checks++; if (nb_a - n0 != (REG ? 4 : 0)) begin errors++; $display("FAIL rmid_fill: got %0d want %0d", nb_a - n0, REG ? 4 : 0); end
        checks++; if (b_valid !== REG || c_valid !== REG) begin errors++; $display("FAIL rmid_held: got b=%b c=%b want %b %b", b_valid, c_valid, REG, REG); end
        rst = 1'b1;
        step();
        rst = 1'b0; b_ready = 1'b1; c_ready = 1'b1;
        #1;
        checks++; if (b_valid !== 1'b0 || c_valid !== 1'b0) begin errors++; $display("FAIL rmid_valids: got b=%b c=%b want 0 0", b_valid, c_valid); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rmid_a_ready: got %b want 1", a_ready); end
        for (int i = 0; i < 3; i++) step();
        checks++; if (got_b.size() != 0 || got_c.size() != 0 || sb_bad != 0) begin
            errors++; $display("FAIL rmid_stale: got b_n=%0d c_n=%0d bad=%0d want 0 0 0", got_b.size(), got_c.size(), sb_bad);
        end
    endtask

    task automatic test_random();
        int   n0;
        logic e_ar;
        logic e_bv;
        logic e_cv;
        clear_log();
        n0 = nb_a;
        for (int i = 0; i < 500; i++) begin
            a_valid = 1'($urandom_range(0, 1));
            sel     = 1'($urandom_range(0, 1));
            b_ready = ($urandom_range(0, 3) != 0);
            c_ready = ($urandom_range(0, 3) != 0);
            a_data  = $urandom;
            #1;
            e_ar = REG ? (sel ? (exp_c.size() < 2) : (exp_b.size() < 2)) : (sel ? c_ready : b_ready);
            e_bv = REG ? (exp_b.size() != 0) : (a_valid && !sel);
            e_cv = REG ? (exp_c.size() != 0) : (a_valid && sel);
            checks++; if (a_ready !== e_ar) begin errors++; $display("FAIL rnd_a_ready: cycle %0d got %b want %b", i, a_ready, e_ar); end
            checks++; if (b_valid !== e_bv) begin errors++; $display("FAIL rnd_b_valid: cycle %0d got %b want %b", i, b_valid, e_bv); end
            checks++; if (c_valid !== e_cv) begin errors++; $display("FAIL rnd_c_valid: cycle %0d got %b want %b", i, c_valid, e_cv); end
            if (e_bv) begin
                checks++; if (b_data !== (REG ? exp_b[0] : a_data)) begin errors++; $display("FAIL rnd_b_data: cycle %0d got %h want %h", i, b_data, REG ? exp_b[0] : a_data); end
            end
            if (e_cv) begin
                checks++; if (c_data !== (REG ? exp_c[0] : a_data)) begin errors++; $display("FAIL rnd_c_data: cycle %0d got %h want %h", i, c_data, REG ? exp_c[0] : a_data); end
            end
            step();
        end
        a_valid = 1'b0; b_ready = 1'b1; c_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++; if (exp_b.size() != 0 || exp_c.size() != 0) begin errors++; $display("FAIL rnd_undelivered: got b=%0d c=%0d want 0 0", exp_b.size(), exp_c.size()); end
        checks++; if (got_b.size() + got_c.size() != nb_a - n0) begin errors++; $display("FAIL rnd_count: got %0d delivered want %0d", got_b.size() + got_c.size(), nb_a - n0); end
        checks++; if (sb_bad != 0 || hold_viol != 0) begin errors++; $display("FAIL rnd_scoreboard: got bad=%0d hold=%0d want 0 0", sb_bad, hold_viol); end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; a_valid = 1'b0; a_data = '0; b_ready = 1'b0; c_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_toggle();
        test_backpressure();
        test_bypass_full();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_stream_demux

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter DATA_WD, default 32, giving the payload width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port sel, input, 1 bit: route select, 0 = output b, 1 = output c.
REQ-005 The block SHALL have ports a_data (input, DATA_WD bits), a_valid (input, 1 bit) and a_ready (output, 1 bit): the upstream stream.
REQ-006 The block SHALL have ports b_data (output, DATA_WD bits), b_valid (output, 1 bit) and b_ready (input, 1 bit): downstream stream b.
REQ-007 The block SHALL have ports c_data (output, DATA_WD bits), c_valid (output, 1 bit) and c_ready (input, 1 bit): downstream stream c.

Function
REQ-008 A transfer on any stream SHALL occur in a cycle where its valid and ready are both 1 ("fire").
REQ-009 On an a fire, the block SHALL route the a_data word to b when sel=0 and to c when sel=1, using sel sampled in the same cycle.
REQ-010 Each a word SHALL appear exactly once, on the selected output only, with no loss or duplication.
REQ-011 Word order SHALL be preserved within each output.
REQ-012 a_ready SHALL equal the accept-capability of the branch selected by the current sel.
REQ-013 The unselected branch SHALL continue draining its pending data independently.
REQ-014 a_ready SHALL NOT depend combinationally on a_valid.
REQ-015 Once b_valid or c_valid is asserted, it SHALL stay at 1 and its data SHALL stay stable until that output fires.
REQ-016 sel may change in any cycle, including the cycle immediately after an a fire; the block SHALL impose no sel stability rule beyond REQ-009.
REQ-017 With registered mode (REQ-023): latency a fire -> output valid SHALL be 1 cycle.
REQ-018 With registered mode: each branch SHALL hold up to 2 words and SHALL sustain 1 word/cycle per branch when its ready is held at 1.
REQ-019 With registered mode: branch accept-capability SHALL be a register, true when fewer than 2 words are held (not full).
REQ-020 Simultaneous input and output fire on the same branch SHALL keep that branch's occupancy unchanged.

Reset
REQ-021 While rst=1: a_ready, b_valid and c_valid SHALL be 0; b_data and c_data SHALL be 0; all branch buffers SHALL be emptied.
REQ-022 Assertion of rst mid-transfer SHALL discard held words; in the first cycle after rst deasserts, a_ready SHALL be 1 and b_valid and c_valid SHALL be 0.

Configuration
REQ-023 Macro STREAM_DEMUX_REG_EN defined: each branch SHALL use a 2-entry skid buffer per REQ-017 to REQ-020, with all outputs registered.
REQ-024 Macro STREAM_DEMUX_REG_EN undefined: the block SHALL be combinational pass-through with 0 latency.
REQ-025 Pass-through behaviour: b_valid = a_valid and !sel; c_valid = a_valid and sel; b_data = c_data = a_data; a_ready = sel ? c_ready : b_ready.
REQ-026 In pass-through mode, rst SHALL have no effect.

Structure
REQ-027 Package stream_pkg SHALL hold the DATA_WD default (32) and the select encoding constants SEL_B=0 and SEL_C=1.
REQ-028 One sub-module, stream_skid_buf (2-entry valid/ready skid buffer, parameter DATA_WD), SHALL be instantiated once per branch in registered mode.

Verification
REQ-029 The bench SHALL run every scenario in both macro settings.
REQ-030 Reset release, sel=0, a_data=0x00000005 valid, b_ready=1 -> registered mode: b_valid=1 with b_data=0x00000005 one cycle after the a fire, and c_valid stays 0.
REQ-031 sel toggling on each a fire, incrementing a_data 0,1,2,3, b_ready=c_ready=1 -> b receives 0,2 and c receives 1,3, in order.
REQ-032 b_ready=0, sel=0, a_valid held at 1 -> registered mode: a_ready drops to 0 after 2 accepted words; b_data stays stable; releasing b_ready delivers both words in order.
REQ-033 b stalled full, sel=1 -> a_ready=1 and words flow to c unimpeded.
REQ-034 rst pulsed while both buffers hold words -> all valids 0 next cycle; no stale word is ever emitted.
REQ-035 Random a_valid, b_ready, c_ready and sel for 500 cycles -> scoreboard shows every word delivered exactly once to the correct output, in order.
